// File: rtl/mux2_1_pkg.sv
// rtl/mux2_1_pkg.sv - shared constants and saturating-increment helper for the mux2_1_reg slice
package mux2_1_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;

  // Counters up to 32 bits are zero-extended into this helper; max is the all-ones value of the real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    logic [31:0] result;
    if (value >= max) begin
      result = max;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux2_1_comb.sv
// rtl/mux2_1_comb.sv - pure combinational WIDTH-bit 2-to-1 selector
module mux2_1_comb
  import mux2_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             s_i,
  output logic [WIDTH-1:0] y_o
);

  // Only a definite 1 picks b; any unknown select falls through to a.
  always_comb begin
    y_o = a_i;
    if (s_i == SEL_B) begin
      y_o = b_i;
    end
  end

endmodule

// File: rtl/mux2_1_reg.sv
// rtl/mux2_1_reg.sv - registered 2-to-1 mux with load enable, valid flag and saturating select-b counter
// Optional combinational bypass output out_comb is added when MUX2_1_REG_BYPASS_EN is defined.
module mux2_1_reg
  import mux2_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic             out_valid,
  output logic [CNT_W-1:0] sel_b_cnt
`ifdef MUX2_1_REG_BYPASS_EN
  ,
  output logic [WIDTH-1:0] out_comb
`endif
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] sel_b_cnt_q, sel_b_cnt_d;

  mux2_1_comb #(
    .WIDTH(WIDTH)
  ) u_sel (
    .a_i(a),
    .b_i(b),
    .s_i(s),
    .y_o(mux_y)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    sel_b_cnt_d = sel_b_cnt_q;
    if (en) begin
      out_d       = mux_y;
      out_valid_d = 1'b1;
      if (s == SEL_B) begin
        sel_b_cnt_d = CNT_W'(sat_inc(32'(sel_b_cnt_q), CNT_MAX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sel_b_cnt_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_b_cnt_q <= sel_b_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel_b_cnt = sel_b_cnt_q;

`ifdef MUX2_1_REG_BYPASS_EN
  assign out_comb = mux_y;
`endif

endmodule

// File: tb/tb_mux2_1_reg.sv
// tb/tb_mux2_1_reg.sv - directed self-checking bench for mux2_1_reg (WIDTH=1 and WIDTH=8/CNT_W=2 instances)
module tb_mux2_1_reg;

  logic clk = 1'b0;
  logic rst_n;

  logic       a1, b1, s1, en1;
  logic       out1, valid1;
  logic [7:0] cnt1;

  logic [7:0] a8, b8;
  logic       s8, en8;
  logic [7:0] out8;
  logic       valid8;
  logic [1:0] cnt8;
`ifdef MUX2_1_REG_BYPASS_EN
  logic       comb1;
  logic [7:0] comb8;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux2_1_reg #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .out(out1), .a(a1), .b(b1), .s(s1), .en(en1),
    .out_valid(valid1), .sel_b_cnt(cnt1)
`ifdef MUX2_1_REG_BYPASS_EN
    , .out_comb(comb1)
`endif
  );

  mux2_1_reg #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .out(out8), .a(a8), .b(b8), .s(s8), .en(en8),
    .out_valid(valid8), .sel_b_cnt(cnt8)
`ifdef MUX2_1_REG_BYPASS_EN
    , .out_comb(comb8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       tt_exp  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; s1 = 1'b1; en1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1; en8 = 1'b1;
    tick();
    tick();
    check("rst_out1", 64'(out1), 64'h0);
    check("rst_valid1", 64'(valid1), 64'h0);
    check("rst_cnt1", 64'(cnt1), 64'h0);
    check("rst_out8", 64'(out8), 64'h0);
    check("rst_valid8", 64'(valid8), 64'h0);
    check("rst_cnt8", 64'(cnt8), 64'h0);

    // Truth table on the 1-bit instance, one vector per cycle.
    @(negedge clk);
    rst_n = 1'b1;
    en8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      s1 = i[2]; a1 = i[1]; b1 = i[0];
      tick();
      check($sformatf("tt_out_%0d", i), 64'(out1), 64'(tt_exp[i]));
      check($sformatf("tt_valid_%0d", i), 64'(valid1), 64'h1);
    end
    check("tt_cnt1", 64'(cnt1), 64'd4);
    check("tt_cnt8_idle", 64'(cnt8), 64'h0);

    @(negedge clk);
    en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    en8 = 1'b1; s8 = 1'b0; a8 = 8'hA5; b8 = 8'h00;
    tick();
    check("hold1_out", 64'(out1), 64'h1);
    check("hold1_valid", 64'(valid1), 64'h0);
    check("load8_out", 64'(out8), 64'hA5);
    check("load8_valid", 64'(valid8), 64'h1);

    @(negedge clk);
    en8 = 1'b0; a8 = 8'h3C;
    tick();
    check("hold8_out", 64'(out8), 64'hA5);
    check("hold8_valid", 64'(valid8), 64'h0);
    tick();
    check("hold8_out2", 64'(out8), 64'hA5);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en8 = 1'b1; s8 = 1'b1; b8 = 8'h10 + 8'(i);
      tick();
      check($sformatf("sat_cnt_%0d", i), 64'(cnt8), 64'(sat_exp[i]));
      check($sformatf("sat_out_%0d", i), 64'(out8), 64'h10 + 64'(i));
    end

    @(negedge clk);
    s8 = 1'b0; a8 = 8'hFF;
    tick();
    check("sel_a_cnt", 64'(cnt8), 64'd3);
    check("sel_a_out", 64'(out8), 64'hFF);

    // Reset with en high must still clear everything on that edge.
    @(negedge clk);
    rst_n = 1'b0; s8 = 1'b1; b8 = 8'h77;
    tick();
    check("midrst_out8", 64'(out8), 64'h0);
    check("midrst_cnt8", 64'(cnt8), 64'h0);
    check("midrst_valid8", 64'(valid8), 64'h0);
    check("midrst_cnt1", 64'(cnt1), 64'h0);

    @(negedge clk);
    rst_n = 1'b1; s8 = 1'b0; a8 = 8'h42;
    tick();
    check("post_rst_out", 64'(out8), 64'h42);
    check("post_rst_valid", 64'(valid8), 64'h1);
    check("post_rst_cnt", 64'(cnt8), 64'h0);

    @(negedge clk);
    en8 = 1'b0;
`ifdef MUX2_1_REG_BYPASS_EN
    s8 = 1'b1; a8 = 8'h00; b8 = 8'h5A;
    #1;
    check("bypass_comb", 64'(comb8), 64'h5A);
    check("bypass_out", 64'(out8), 64'h42);
    s8 = 1'b0;
    #1;
    check("bypass_comb_a", 64'(comb8), 64'h00);
`endif
    tick();
    check("final_out", 64'(out8), 64'h42);
    check("final_valid", 64'(valid8), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
